// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers:
// control-vector bit map, stage occupancy states and default widths.
package pipe_pkg;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_MEMREAD  = 2;
   localparam int CTRL_MEMWRITE = 3;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_DATA = 2;
   localparam int DEF_CTRL_W   = 4;
   localparam int DEF_RD_W     = 5;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stageState_t;

endpackage

// File: rtl/pipe_entry.sv
// One storage entry of an elastic pipeline register: valid bit, control
// vector, data words and destination index. A flush (clearCtrl) kills the
// entry but leaves data/rd untouched; reset clears everything.
module pipe_entry import pipe_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_DATA = DEF_NUM_DATA,
   parameter int CTRL_W   = DEF_CTRL_W,
   parameter int RD_W     = DEF_RD_W
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic                       drop,
   input  logic                       clearCtrl,
   input  logic [CTRL_W-1:0]          loadCtrl,
   input  logic [NUM_DATA*DATA_W-1:0] loadData,
   input  logic [RD_W-1:0]            loadRd,
   output logic                       entValid,
   output logic [CTRL_W-1:0]          entCtrl,
   output logic [NUM_DATA*DATA_W-1:0] entData,
   output logic [RD_W-1:0]            entRd
);

   // Flush outranks load so an incoming beat in a flush cycle becomes a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         entValid <= 1'b0;
         entCtrl  <= '0;
         entData  <= '0;
         entRd    <= '0;
      end else if (clearCtrl) begin
         entValid <= 1'b0;
         entCtrl  <= '0;
      end else if (load) begin
         entValid <= 1'b1;
         entCtrl  <= loadCtrl;
         entData  <= loadData;
         entRd    <= loadRd;
      end else if (drop) begin
         entValid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between MIPS stages with valid/ready handshake
// and flush. Define PIPE_STAGE_SKID_EN to add a second (skid) entry so that
// in_ready comes straight from a flop instead of from out_ready.
module pipe_stage_reg import pipe_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_DATA = DEF_NUM_DATA,
   parameter int CTRL_W   = DEF_CTRL_W,
   parameter int RD_W     = DEF_RD_W
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]            in_rd,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [NUM_DATA*DATA_W-1:0] out_data,
   output logic [RD_W-1:0]            out_rd
);

   localparam int DW = NUM_DATA * DATA_W;

   stageState_t       stateQ;
   stageState_t       stateD;
   logic              acceptBeat;
   logic              releaseBeat;
   logic              loadMain;
   logic              dropMain;
   logic              mainValid;
   logic [CTRL_W-1:0] mainCtrl;
   logic [DW-1:0]     mainData;
   logic [RD_W-1:0]   mainRd;
   logic [CTRL_W-1:0] mainSrcCtrl;
   logic [DW-1:0]     mainSrcData;
   logic [RD_W-1:0]   mainSrcRd;

   assign acceptBeat  = in_valid & in_ready;
   assign releaseBeat = mainValid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              loadSkid;
   logic              dropSkid;
   logic              skidValid;
   logic [CTRL_W-1:0] skidCtrl;
   logic [DW-1:0]     skidData;
   logic [RD_W-1:0]   skidRd;
   logic              inReadyQ;

   // The skid entry is only valid in state TWO, so it doubles as the MAIN source select.
   assign mainSrcCtrl = skidValid ? skidCtrl : in_ctrl;
   assign mainSrcData = skidValid ? skidData : in_data;
   assign mainSrcRd   = skidValid ? skidRd   : in_rd;

   // Register in_ready from the next state so out_ready never reaches upstream combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         inReadyQ <= 1'b1;
      end else begin
         inReadyQ <= (stateD != ST_TWO);
      end
   end

   assign in_ready = inReadyQ;

   pipe_entry #(
      .DATA_W   (DATA_W),
      .NUM_DATA (NUM_DATA),
      .CTRL_W   (CTRL_W),
      .RD_W     (RD_W)
   ) skidEntry (
      .clk       (clk),
      .rst       (rst),
      .load      (loadSkid),
      .drop      (dropSkid),
      .clearCtrl (flush),
      .loadCtrl  (in_ctrl),
      .loadData  (in_data),
      .loadRd    (in_rd),
      .entValid  (skidValid),
      .entCtrl   (skidCtrl),
      .entData   (skidData),
      .entRd     (skidRd)
   );
`else
   assign mainSrcCtrl = in_ctrl;
   assign mainSrcData = in_data;
   assign mainSrcRd   = in_rd;
   assign in_ready    = out_ready | ~mainValid;
`endif

   // Occupancy state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= ST_EMPTY;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state and entry load/drop decisions; flush forces EMPTY regardless of handshakes.
   always_comb begin
      stateD   = stateQ;
      loadMain = 1'b0;
      dropMain = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      loadSkid = 1'b0;
      dropSkid = 1'b0;
`endif
      case (stateQ)
         ST_EMPTY: begin
            if (acceptBeat) begin
               loadMain = 1'b1;
               stateD   = ST_ONE;
            end
         end
         ST_ONE: begin
            if (acceptBeat && releaseBeat) begin
               loadMain = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            end else if (acceptBeat) begin
               loadSkid = 1'b1;
               stateD   = ST_TWO;
`endif
            end else if (releaseBeat) begin
               dropMain = 1'b1;
               stateD   = ST_EMPTY;
            end
         end
`ifdef PIPE_STAGE_SKID_EN
         ST_TWO: begin
            if (releaseBeat) begin
               loadMain = 1'b1;
               dropSkid = 1'b1;
               stateD   = ST_ONE;
            end
         end
`endif
         default: begin
            stateD = ST_EMPTY;
         end
      endcase
      if (flush) begin
         stateD = ST_EMPTY;
      end
   end

   pipe_entry #(
      .DATA_W   (DATA_W),
      .NUM_DATA (NUM_DATA),
      .CTRL_W   (CTRL_W),
      .RD_W     (RD_W)
   ) mainEntry (
      .clk       (clk),
      .rst       (rst),
      .load      (loadMain),
      .drop      (dropMain),
      .clearCtrl (flush),
      .loadCtrl  (mainSrcCtrl),
      .loadData  (mainSrcData),
      .loadRd    (mainSrcRd),
      .entValid  (mainValid),
      .entCtrl   (mainCtrl),
      .entData   (mainData),
      .entRd     (mainRd)
   );

   assign out_valid = mainValid;
   assign out_ctrl  = mainValid ? mainCtrl : '0;
   assign out_data  = mainData;
   assign out_rd    = mainRd;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg. Works with and without PIPE_STAGE_SKID_EN;
// the reference model is a queue of held beats with a capacity limit.
module tb_pipe_stage_reg;

   localparam int DATA_W   = 32;
   localparam int NUM_DATA = 2;
   localparam int CTRL_W   = 4;
   localparam int RD_W     = 5;
   localparam int DW       = NUM_DATA * DATA_W;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DW-1:0]     data;
      logic [RD_W-1:0]   rd;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DW-1:0]     in_data;
   logic [RD_W-1:0]   in_rd;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DW-1:0]     out_data;
   logic [RD_W-1:0]   out_rd;

   beat_t modelQ[$];
   int    vectors     = 0;
   int    miscompares = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W   (DATA_W),
      .NUM_DATA (NUM_DATA),
      .CTRL_W   (CTRL_W),
      .RD_W     (RD_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .in_rd     (in_rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .out_rd    (out_rd)
   );

   // Model of in_ready: skid stage takes beats until two are held, plain stage when empty or draining.
   function automatic logic expInReady();
`ifdef PIPE_STAGE_SKID_EN
      return modelQ.size() < 2;
`else
      return (modelQ.size() == 0) || (out_ready == 1'b1);
`endif
   endfunction

   // Drive one cycle's inputs after the falling edge and let combinational outputs settle.
   task automatic applyStimulus(input logic r, input logic fl, input logic v,
                                input logic [CTRL_W-1:0] c, input logic [DW-1:0] d,
                                input logic [RD_W-1:0] rdIdx, input logic ordy);
      @(negedge clk);
      rst       = r;
      flush     = fl;
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      in_rd     = rdIdx;
      out_ready = ordy;
      #1;
   endtask

   // Advance the queue model by the handshakes of the current cycle.
   task automatic commitCycle();
      logic  acc;
      logic  rel;
      beat_t b;
      acc = in_valid && expInReady();
      rel = (modelQ.size() > 0) && out_ready;
      if (rst || flush) begin
         modelQ.delete();
      end else begin
         if (rel) void'(modelQ.pop_front());
         if (acc) begin
            b.ctrl = in_ctrl;
            b.data = in_data;
            b.rd   = in_rd;
            modelQ.push_back(b);
         end
      end
   endtask

   task automatic test_reset();
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            for (int k = 0; k < 3; k++) begin
               applyStimulus(0, 0, 1, 4'hF, {$urandom, $urandom}, RD_W'(k + 1), 0);
               commitCycle();
            end
         end
         for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 0, 1, 4'hF, {$urandom, $urandom}, 5'd31, 0);
            commitCycle();
         end
         applyStimulus(0, 0, 0, 4'h0, '0, '0, 0);
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset.out_valid pass=%0d got=%0b exp=0", pass, out_valid);
         end
         vectors++;
         if (out_ctrl !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL reset.out_ctrl pass=%0d got=%h exp=0", pass, out_ctrl);
         end
         vectors++;
         if (out_data !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset.out_data pass=%0d got=%h exp=0", pass, out_data);
         end
         vectors++;
         if (out_rd !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset.out_rd pass=%0d got=%0d exp=0", pass, out_rd);
         end
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset.in_ready pass=%0d got=%0b exp=1", pass, in_ready);
         end
         commitCycle();
      end
   endtask

   task automatic test_streaming();
      logic [DW-1:0] expData;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 0, (k < 8), CTRL_W'(k + 1),
                       {32'(k * 32'h11 + 32'h1000), 32'(k * 32'h11)}, RD_W'(k), 1);
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stream.in_ready k=%0d got=%0b exp=1", k, in_ready);
         end
         if (k >= 1 && k <= 8) begin
            expData = {32'((k - 1) * 32'h11 + 32'h1000), 32'((k - 1) * 32'h11)};
            vectors++;
            if (out_valid !== 1'b1 || out_data !== expData || out_rd !== RD_W'(k - 1)
                || out_ctrl !== CTRL_W'(k)) begin
               miscompares++;
               $display("[TB] FAIL stream.beat k=%0d got v=%0b d=%h rd=%0d c=%h exp v=1 d=%h rd=%0d c=%h",
                        k, out_valid, out_data, out_rd, out_ctrl, expData, k - 1, CTRL_W'(k));
            end
         end else if (k == 9) begin
            vectors++;
            if (out_valid !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL stream.tail got=%0b exp=0", out_valid);
            end
         end
         commitCycle();
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] dataA;
      logic [DW-1:0] dataB;
      dataA = 64'hAAAA_0001_AAAA_0002;
      dataB = 64'hBBBB_0003_BBBB_0004;
      applyStimulus(0, 0, 1, 4'h1, dataA, 5'd10, 0);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL bp.first_ready got=%0b exp=1", in_ready);
      end
      commitCycle();
`ifdef PIPE_STAGE_SKID_EN
      applyStimulus(0, 0, 1, 4'h2, dataB, 5'd11, 0);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== dataA) begin
         miscompares++;
         $display("[TB] FAIL bp.second_accept got rdy=%0b v=%0b d=%h exp rdy=1 v=1 d=%h",
                  in_ready, out_valid, out_data, dataA);
      end
      commitCycle();
      applyStimulus(0, 0, 0, 4'h0, '0, '0, 0);
      vectors++;
      if (in_ready !== 1'b0 || out_data !== dataA) begin
         miscompares++;
         $display("[TB] FAIL bp.full got rdy=%0b d=%h exp rdy=0 d=%h", in_ready, out_data, dataA);
      end
      commitCycle();
      applyStimulus(0, 0, 0, 4'h0, '0, '0, 1);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== dataA || out_rd !== 5'd10) begin
         miscompares++;
         $display("[TB] FAIL bp.drainA got rdy=%0b v=%0b d=%h rd=%0d exp rdy=0 v=1 d=%h rd=10",
                  in_ready, out_valid, out_data, out_rd, dataA);
      end
      commitCycle();
`else
      applyStimulus(0, 0, 1, 4'h2, dataB, 5'd11, 0);
      vectors++;
      if (in_ready !== 1'b0 || out_data !== dataA) begin
         miscompares++;
         $display("[TB] FAIL bp.stall_ready got rdy=%0b d=%h exp rdy=0 d=%h", in_ready, out_data, dataA);
      end
      commitCycle();
      applyStimulus(0, 0, 1, 4'h2, dataB, 5'd11, 1);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== dataA || out_rd !== 5'd10) begin
         miscompares++;
         $display("[TB] FAIL bp.release_ready got rdy=%0b v=%0b d=%h rd=%0d exp rdy=1 v=1 d=%h rd=10",
                  in_ready, out_valid, out_data, out_rd, dataA);
      end
      commitCycle();
`endif
      applyStimulus(0, 0, 0, 4'h0, '0, '0, 1);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== dataB || out_rd !== 5'd11
          || out_ctrl !== 4'h2) begin
         miscompares++;
         $display("[TB] FAIL bp.drainB got rdy=%0b v=%0b d=%h rd=%0d c=%h exp rdy=1 v=1 d=%h rd=11 c=2",
                  in_ready, out_valid, out_data, out_rd, out_ctrl, dataB);
      end
      commitCycle();
      applyStimulus(0, 0, 0, 4'h0, '0, '0, 1);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL bp.empty got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
      end
      commitCycle();
   endtask

   task automatic test_flush();
      logic [DW-1:0] dataA;
      dataA = 64'h1234_5678_9ABC_DEF0;
      applyStimulus(0, 0, 1, 4'h5, dataA, 5'd3, 0);
      commitCycle();
`ifdef PIPE_STAGE_SKID_EN
      applyStimulus(0, 0, 1, 4'h6, 64'h0F0F_0F0F_0F0F_0F0F, 5'd4, 0);
      commitCycle();
      applyStimulus(0, 1, 1, 4'hF, 64'hDEAD_BEEF_DEAD_BEEF, 5'd7, 0);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== dataA) begin
         miscompares++;
         $display("[TB] FAIL flush.before got rdy=%0b v=%0b d=%h exp rdy=0 v=1 d=%h",
                  in_ready, out_valid, out_data, dataA);
      end
`else
      applyStimulus(0, 1, 1, 4'hF, 64'hDEAD_BEEF_DEAD_BEEF, 5'd7, 1);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== dataA) begin
         miscompares++;
         $display("[TB] FAIL flush.before got rdy=%0b v=%0b d=%h exp rdy=1 v=1 d=%h",
                  in_ready, out_valid, out_data, dataA);
      end
`endif
      commitCycle();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, 4'h0, '0, '0, 1);
         vectors++;
         if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush.after k=%0d got v=%0b c=%h rdy=%0b exp v=0 c=0 rdy=1",
                     k, out_valid, out_ctrl, in_ready);
         end
         commitCycle();
      end
   endtask

   task automatic test_random();
      logic  r;
      logic  fl;
      logic  v;
      logic  ordy;
      beat_t head;
      for (int n = 0; n < 10000; n++) begin
         r    = ($urandom_range(0, 399) == 0);
         fl   = ($urandom_range(0, 49) == 0);
         v    = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 6);
         applyStimulus(r, fl, v, CTRL_W'($urandom), {$urandom, $urandom}, RD_W'($urandom), ordy);
         vectors++;
         if (in_ready !== expInReady()) begin
            miscompares++;
            $display("[TB] FAIL rand.in_ready n=%0d got=%0b exp=%0b", n, in_ready, expInReady());
         end
         vectors++;
         if (out_valid !== (modelQ.size() > 0)) begin
            miscompares++;
            $display("[TB] FAIL rand.out_valid n=%0d got=%0b exp=%0b", n, out_valid, modelQ.size() > 0);
         end
         if (modelQ.size() > 0) begin
            head = modelQ[0];
            vectors++;
            if (out_ctrl !== head.ctrl || out_data !== head.data || out_rd !== head.rd) begin
               miscompares++;
               $display("[TB] FAIL rand.beat n=%0d got c=%h d=%h rd=%0d exp c=%h d=%h rd=%0d",
                        n, out_ctrl, out_data, out_rd, head.ctrl, head.data, head.rd);
            end
         end else begin
            vectors++;
            if (out_ctrl !== 4'h0) begin
               miscompares++;
               $display("[TB] FAIL rand.bubble_ctrl n=%0d got=%h exp=0", n, out_ctrl);
            end
         end
         commitCycle();
      end
   endtask

   // Run every scenario in order and report the totals.
   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_ctrl   = '0;
      in_data   = '0;
      in_rd     = '0;
      out_ready = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
